approx_adder_error_monitor: RTL

Sequential characterisation stage wrapped around one combinational approximate adder netlist with an `in0..in3 / out0..out2` interface. It sits upstream of the adder, driving every operand pair in turn, and downstream of it, consuming the approximate sum and comparing it with the exact sum. For each exhaustive sweep it reports the worst-case absolute error, the error count and the summed absolute error. It also flags when the error threshold (ET) is exceeded, so synthesised approximations can be checked against their ET in simulation or on FPGA.

---
 rtl/approx_adder_error_monitor_pkg.sv | 15 +
 rtl/approx_adder_error_monitor_if.sv | 23 ++
 rtl/approx_err_accum.sv | 46 ++++
 rtl/approx_adder_error_monitor.sv | 63 ++++++
 4 files changed

// File: rtl/approx_adder_error_monitor_pkg.sv
// approx_mon_pkg: shared FSM state type and width helpers for the approximate adder error monitor
package approx_mon_pkg;
    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
    localparam int DEF_IN_BITS = 2;
    localparam int DEF_ET = 2;
    function automatic int n_vec(input int in_bits);
        return 1 << (2 * in_bits);
    endfunction
    function automatic int cnt_w(input int in_bits);
        return 2 * in_bits + 1;
    endfunction
    function automatic int sum_w(input int in_bits, input int out_bits);
        return out_bits + 2 * in_bits;
    endfunction
endpackage

// File: rtl/approx_adder_error_monitor_if.sv
// approx_adder_error_monitor_if: adder stimulus/response and result bundle of the error monitor
interface approx_adder_error_monitor_if import approx_mon_pkg::*; #(
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = IN_BITS + 1
);
    logic                             i_start;
    logic [2*IN_BITS-1:0]             o_stim;
    logic [OUT_BITS-1:0]              i_approx_sum;
    logic                             o_busy;
    logic                             o_done;
    logic [OUT_BITS-1:0]              o_max_err;
    logic [2*IN_BITS:0]               o_err_count;
    logic [OUT_BITS+2*IN_BITS-1:0]    o_sum_abs_err;
    logic                             o_violation;
    modport master (
        output i_start, i_approx_sum,
        input  o_stim, o_busy, o_done, o_max_err, o_err_count, o_sum_abs_err, o_violation
    );
    modport slave (
        input  i_start, i_approx_sum,
        output o_stim, o_busy, o_done, o_max_err, o_err_count, o_sum_abs_err, o_violation
    );
endinterface

// File: rtl/approx_err_accum.sv
// approx_err_accum: accumulates worst-case, count and sum of absolute adder errors
module approx_err_accum import approx_mon_pkg::*; #(
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = IN_BITS + 1,
    parameter int ET       = DEF_ET
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_clear,
    input  logic                                   i_valid,
    input  logic [OUT_BITS-1:0]                    i_exact,
    input  logic [OUT_BITS-1:0]                    i_approx,
    output logic [OUT_BITS-1:0]                    o_max_err,
    output logic [cnt_w(IN_BITS)-1:0]              o_err_count,
    output logic [sum_w(IN_BITS, OUT_BITS)-1:0]    o_sum_abs_err,
    output logic                                   o_violation
);
    localparam int CW = cnt_w(IN_BITS);
    localparam int SW = sum_w(IN_BITS, OUT_BITS);
    localparam logic [OUT_BITS-1:0] ET_V = OUT_BITS'(ET);
    logic [OUT_BITS-1:0] r_max, w_err, w_max;
    logic [CW-1:0]       r_cnt;
    logic [SW-1:0]       r_sum;
    logic                r_viol;
    always_comb begin
        w_err = (i_exact >= i_approx) ? i_exact - i_approx : i_approx - i_exact;
        w_max = (w_err > r_max) ? w_err : r_max;
    end
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_max  <= '0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_viol <= 1'b0;
        end else if (i_valid) begin
            r_max  <= w_max;
            r_cnt  <= r_cnt + CW'(w_err != '0);
            r_sum  <= r_sum + SW'(w_err);
            r_viol <= w_max > ET_V;
        end
    end
    assign o_max_err     = r_max;
    assign o_err_count   = r_cnt;
    assign o_sum_abs_err = r_sum;
    assign o_violation   = r_viol;
endmodule

// File: rtl/approx_adder_error_monitor.sv
// approx_adder_error_monitor: exhaustive sweep of an approximate adder with error statistics
module approx_adder_error_monitor import approx_mon_pkg::*; #(
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = IN_BITS + 1,
    parameter int ET       = DEF_ET
) (
    input logic                         clk,
    input logic                         rst,
    approx_adder_error_monitor_if.slave bus
);
    localparam int AW = 2 * IN_BITS;
    localparam logic [AW-1:0] LAST = AW'(n_vec(IN_BITS) - 1);
    state_t                        r_state, w_next;
    logic [AW-1:0]                 r_index;
    logic                          r_p1_valid;
    logic [OUT_BITS-1:0]           r_p1_exact, r_p1_approx;
    logic                          w_accept;
    logic [OUT_BITS-1:0]           w_max_err;
    logic [cnt_w(IN_BITS)-1:0]     w_err_count;
    logic [sum_w(IN_BITS, OUT_BITS)-1:0] w_sum_abs_err;
    logic                          w_violation;
    always_comb begin
        w_accept = bus.i_start && (r_state == IDLE || r_state == DONE);
        w_next   = w_accept ? SWEEP :
                   r_state == SWEEP ? (r_index == LAST ? DRAIN : SWEEP) :
                   r_state == DRAIN ? DONE : IDLE;
    end
    // index returns to 0 on its own when the last vector rolls over
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_index     <= '0;
            r_p1_valid  <= 1'b0;
            r_p1_exact  <= '0;
            r_p1_approx <= '0;
        end else begin
            r_state     <= w_next;
            r_index     <= (r_state == SWEEP) ? r_index + 1'b1 : '0;
            r_p1_valid  <= r_state == SWEEP;
            r_p1_exact  <= OUT_BITS'(r_index[IN_BITS-1:0]) + OUT_BITS'(r_index[AW-1:IN_BITS]);
            r_p1_approx <= bus.i_approx_sum;
        end
    end
    approx_err_accum #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .ET(ET)) u_accum (
        .clk           (clk),
        .rst           (rst),
        .i_clear       (w_accept),
        .i_valid       (r_p1_valid),
        .i_exact       (r_p1_exact),
        .i_approx      (r_p1_approx),
        .o_max_err     (w_max_err),
        .o_err_count   (w_err_count),
        .o_sum_abs_err (w_sum_abs_err),
        .o_violation   (w_violation)
    );
    assign bus.o_stim        = r_index;
    assign bus.o_busy        = r_state == SWEEP || r_state == DRAIN;
    assign bus.o_done        = r_state == DONE;
    assign bus.o_max_err     = w_max_err;
    assign bus.o_err_count   = w_err_count;
    assign bus.o_sum_abs_err = w_sum_abs_err;
    assign bus.o_violation   = w_violation;
endmodule
